// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write path: FSM state encoding and the
// default abandon timeout for a single byte write.
package lcd_pkg;

  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd20000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/lcd_write_arbiter.sv
// Two-requester round-robin arbiter in front of the I2C byte-write engine.
// The owner keeps the engine for its whole burst; a stalled engine is abandoned after TIMEOUT_CYC cycles.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       cd0,
  input  logic       cd1,
  input  logic       last0,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic       grant0,
  output logic       grant1,
  output logic       ena_write,
  output logic [7:0] data,
  output logic       cmd_data,
  input  logic       done_write,
  output logic       busy,
  output logic       timeout_err
);

  logic [2:0]  state;
  logic        owner;
  logic        ptr;
  logic        last_q;
  logic [15:0] cnt;

  logic        pick;
  logic        src;
  logic        owner_req;
  logic [7:0]  sel_data;
  logic        sel_cd;
  logic        sel_last;

  // The pointer only breaks ties; a lone requester always wins.
  assign pick      = (req0 && req1) ? ptr : req1;
  assign owner_req = owner ? req1 : req0;
  assign src       = (state == ST_HOLD) ? owner : pick;
  assign sel_data  = src ? data1 : data0;
  assign sel_cd    = src ? cd1   : cd0;
  assign sel_last  = src ? last1 : last0;

  assign ena_write = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign grant0    = busy && !owner;
  assign grant1    = busy && owner;
  assign ack0      = (state == ST_ACK) && !owner;
  assign ack1      = (state == ST_ACK) && owner;

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      ptr         <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= 16'd0;
      data        <= 8'h00;
      cmd_data    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            data     <= sel_data;
            cmd_data <= sel_cd;
            last_q   <= sel_last;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= 16'd0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // cnt holds the number of WAIT cycles already elapsed before this one
          if (done_write) begin
            state <= ST_ACK;
          end else if (cnt == TIMEOUT_CYC - 16'd1) begin
            timeout_err <= 1'b1;
            ptr         <= !owner;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_ACK: begin
          if (last_q) begin
            ptr   <= !owner;
            state <= ST_IDLE;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (owner_req) begin
            data     <= sel_data;
            cmd_data <= sel_cd;
            last_q   <= sel_last;
            state    <= ST_ISSUE;
          end else begin
            ptr   <= !owner;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: requester and engine models drive the DUT,
// a monitor pops expected writes/acks whenever the DUT presents them.
module tb_lcd_write_arbiter;

  logic       clk_1MHz;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       cd0, cd1, last0, last1;
  logic       ack0, ack1, grant0, grant1, ena_write;
  logic [7:0] data;
  logic       cmd_data, done_write, busy, timeout_err;

  logic       done_eng, done_stim, engine_en;
  logic       done_last;

  int checks = 0;
  int errors = 0;

  // expected write: {grant1, grant0, cmd_data, data}; expected ack: {ack1, ack0}
  logic [10:0] exp_wr[$];
  logic [1:0]  exp_ack[$];
  // requester byte queues: {cd, last, data}
  logic [9:0]  rq0[$];
  logic [9:0]  rq1[$];

  assign done_write = done_eng | done_stim;

  lcd_write_arbiter #(.TIMEOUT_CYC(16'd16)) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .cd0(cd0), .cd1(cd1), .last0(last0), .last1(last1),
    .ack0(ack0), .ack1(ack1), .grant0(grant0), .grant1(grant1),
    .ena_write(ena_write), .data(data), .cmd_data(cmd_data),
    .done_write(done_write), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk_1MHz = 1'b0;
    forever #5 clk_1MHz = ~clk_1MHz;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester models: present the head of the queue, pop it on ack.
  initial begin
    req0 = 1'b0; data0 = 8'h00; cd0 = 1'b0; last0 = 1'b0;
    forever begin
      @(negedge clk_1MHz);
      if (ack0 && rq0.size() > 0) void'(rq0.pop_front());
      if (rq0.size() > 0) begin
        req0 = 1'b1;
        {cd0, last0, data0} = rq0[0];
      end else begin
        req0 = 1'b0;
      end
    end
  end

  initial begin
    req1 = 1'b0; data1 = 8'h00; cd1 = 1'b0; last1 = 1'b0;
    forever begin
      @(negedge clk_1MHz);
      if (ack1 && rq1.size() > 0) void'(rq1.pop_front());
      if (rq1.size() > 0) begin
        req1 = 1'b1;
        {cd1, last1, data1} = rq1[0];
      end else begin
        req1 = 1'b0;
      end
    end
  end

  // Engine model: done_write during the first WAIT cycle.
  initial begin
    done_eng = 1'b0;
    forever begin
      @(negedge clk_1MHz);
      if (ena_write && engine_en) begin
        @(posedge clk_1MHz); #1 done_eng = 1'b1;
        @(posedge clk_1MHz); #1 done_eng = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    done_last = 1'b0;
    forever begin
      @(negedge clk_1MHz);
      if (rst_n) begin
        chk("grant_vs_busy", 32'(grant0) + 32'(grant1), 32'(busy));
        if (ena_write) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write actual=%0h required=none", {grant1, grant0, cmd_data, data});
          end else begin
            chk("write", 32'({grant1, grant0, cmd_data, data}), 32'(exp_wr.pop_front()));
          end
        end
        if (ack0 || ack1) begin
          chk("ack_latency", 32'(done_last), 32'd1);
          if (exp_ack.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack actual=%0h required=none", {ack1, ack0});
          end else begin
            chk("ack", 32'({ack1, ack0}), 32'(exp_ack.pop_front()));
          end
        end
      end
      done_last = done_write;
    end
  end

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || busy) && n < max_cyc) begin
      @(negedge clk_1MHz);
      n++;
    end
    chk(name, 32'(n < max_cyc), 32'd1);
    repeat (2) @(negedge clk_1MHz);
  endtask

  task automatic wait_ena(input string name, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk_1MHz);
      n++;
    end while (!ena_write && n < max_cyc);
    chk(name, 32'(ena_write), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; engine_en = 1'b1; done_stim = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    chk("rst_ena", 32'(ena_write), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_cmd", 32'(cmd_data), 32'd0);
    chk("rst_grants", 32'({grant1, grant0}), 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_busy_err", 32'({busy, timeout_err}), 32'd0);
    @(posedge clk_1MHz); #1 rst_n = 1'b1;

    // Both single bytes at once: req0 first (pointer 0), then req1
    @(posedge clk_1MHz); #1;
    exp_wr.push_back({2'b01, 1'b1, 8'h41}); exp_ack.push_back(2'b01);
    exp_wr.push_back({2'b10, 1'b0, 8'h01}); exp_ack.push_back(2'b10);
    rq0.push_back({1'b1, 1'b1, 8'h41});
    rq1.push_back({1'b0, 1'b1, 8'h01});
    @(negedge clk_1MHz);
    @(negedge clk_1MHz);
    chk("req_to_ena_latency", 32'({ena_write, grant0}), 32'b11);
    wait_idle("t1_done", 60);

    // Three-byte burst on req0 with req1 pending throughout
    @(posedge clk_1MHz); #1;
    exp_wr.push_back({2'b01, 1'b1, 8'h48}); exp_ack.push_back(2'b01);
    exp_wr.push_back({2'b01, 1'b1, 8'h49}); exp_ack.push_back(2'b01);
    exp_wr.push_back({2'b01, 1'b0, 8'h21}); exp_ack.push_back(2'b01);
    exp_wr.push_back({2'b10, 1'b0, 8'h80}); exp_ack.push_back(2'b10);
    rq0.push_back({1'b1, 1'b0, 8'h48});
    rq0.push_back({1'b1, 1'b0, 8'h49});
    rq0.push_back({1'b0, 1'b1, 8'h21});
    rq1.push_back({1'b0, 1'b1, 8'h80});
    wait_idle("burst_done", 100);

    // Owner abandons in HOLD; pointer flips so req1 wins the next tie
    @(posedge clk_1MHz); #1;
    exp_wr.push_back({2'b01, 1'b1, 8'h55}); exp_ack.push_back(2'b01);
    rq0.push_back({1'b1, 1'b0, 8'h55});
    wait_idle("abandon_done", 60);
    @(posedge clk_1MHz); #1;
    exp_wr.push_back({2'b10, 1'b1, 8'h66}); exp_ack.push_back(2'b10);
    exp_wr.push_back({2'b01, 1'b1, 8'h67}); exp_ack.push_back(2'b01);
    rq0.push_back({1'b1, 1'b1, 8'h67});
    rq1.push_back({1'b1, 1'b1, 8'h66});
    wait_idle("after_abandon_done", 60);

    // Engine silent: req1 owns (pointer 1), times out after 16 WAIT cycles
    engine_en = 1'b0;
    @(posedge clk_1MHz); #1;
    exp_wr.push_back({2'b10, 1'b1, 8'h5A});
    exp_wr.push_back({2'b01, 1'b0, 8'h33}); exp_ack.push_back(2'b01);
    exp_wr.push_back({2'b10, 1'b1, 8'h5A}); exp_ack.push_back(2'b10);
    rq1.push_back({1'b1, 1'b1, 8'h5A});
    rq0.push_back({1'b0, 1'b1, 8'h33});
    wait_ena("timeout_issue_seen", 20);
    n = 0;
    do begin
      @(negedge clk_1MHz);
      n++;
    end while (!timeout_err && n < 100);
    chk("timeout_cycles", 32'(n), 32'd17);
    chk("timeout_release", 32'({busy, grant1, grant0, ack1, ack0}), 32'd0);
    engine_en = 1'b1;
    wait_idle("timeout_recover_done", 80);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT, then a spurious done_write
    engine_en = 1'b0;
    @(posedge clk_1MHz); #1;
    exp_wr.push_back({2'b01, 1'b1, 8'h77});
    rq0.push_back({1'b1, 1'b1, 8'h77});
    wait_ena("reset_issue_seen", 20);
    @(negedge clk_1MHz);
    #2 rst_n = 1'b0;
    rq0.delete();
    #1;
    chk("reset_midburst", 32'({ena_write, data, cmd_data, grant1, grant0, ack1, ack0, busy, timeout_err}), 32'd0);
    @(negedge clk_1MHz);
    @(posedge clk_1MHz); #1 rst_n = 1'b1;
    @(posedge clk_1MHz); #1 done_stim = 1'b1;
    @(posedge clk_1MHz); #1 done_stim = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_1MHz);
      chk("spurious_done_no_ack", 32'({ack1, ack0, busy}), 32'd0);
    end
    engine_en = 1'b1;

    chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    chk("acks_drained", 32'(exp_ack.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC: default 16'd20000; number of clk_1MHz cycles to wait for done_write before abandoning a byte.
REQ-002 clk_1MHz  input  1  system clock (1 MHz).
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester i holds a byte pending.
REQ-005 data0, data1  input  8 each  byte to send for requester i; stable while req_i is high and ack_i is low.
REQ-006 cd0, cd1  input  1 each  requester i command(0)/data(1) select.
REQ-007 last0, last1  input  1 each  requester i byte is the final byte of its burst.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: byte of requester i has been written.
REQ-009 grant0, grant1  output  1 each  requester i owns the write engine.
REQ-010 ena_write  output  1  one-cycle start pulse to the I2C byte-write engine.
REQ-011 data  output  8  byte presented to the engine.
REQ-012 cmd_data  output  1  command/data select presented to the engine.
REQ-013 done_write  input  1  one-cycle completion pulse from the engine.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  sticky flag: a byte write timed out.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT, ACK and HOLD.
REQ-017 IDLE: when any req is high, the block SHALL grant one requester, latch its data/cd/last into the output registers and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin with a 1-bit priority pointer that is 0 after reset; when both reqs are high in IDLE, the requester at the pointer SHALL win.
REQ-019 The pointer SHALL flip to the other requester whenever ownership is released (last byte, abandon or timeout).
REQ-020 ISSUE SHALL last exactly one cycle, with ena_write=1, and SHALL then go to WAIT.
REQ-021 data and cmd_data SHALL hold the latched values from ISSUE until the next ISSUE.
REQ-022 WAIT SHALL count cycles in a 16-bit counter, cleared on entry.
REQ-023 In WAIT, done_write=1 SHALL move the FSM to ACK.
REQ-024 In WAIT, a count equal to TIMEOUT_CYC without done_write SHALL set timeout_err, drop the grant, raise no ack and go to IDLE.
REQ-025 ACK SHALL last one cycle with ack of the owner equal to 1; it SHALL go to IDLE if the latched last=1, else to HOLD.
REQ-026 HOLD (burst locked): if the owner's req is high, the block SHALL latch its inputs and go to ISSUE; if it is low, the burst is abandoned and the block SHALL release ownership and go to IDLE.
REQ-027 In HOLD, the non-owner's req SHALL be ignored.
REQ-028 The owner's grant SHALL stay high from the IDLE exit through ACK/HOLD until release; at most one grant SHALL be high at a time.
REQ-029 done_write SHALL be ignored in IDLE, ISSUE, ACK and HOLD.
REQ-030 Minimum byte-to-byte spacing inside a burst SHALL be ISSUE + WAIT(≥1) + ACK + HOLD = 4 cycles.
REQ-031 Latency from req high in IDLE to ena_write SHALL be 1 cycle.

Reset
REQ-032 Asserting rst_n SHALL immediately force: state IDLE, ena_write 0, data 8'h00, cmd_data 0, grants 0, acks 0, busy 0, timeout_err 0, pointer 0, counter 0.
REQ-033 Reset mid-burst SHALL abandon the burst with no ack.
REQ-034 timeout_err SHALL be cleared only by reset.

Structure
REQ-035 The state encoding and the TIMEOUT_CYC default SHALL live in the shared package lcd_pkg.
REQ-036 The block SHALL be a single flat module with no sub-module; the timeout counter and the arbiter SHALL be inline.

Verification
REQ-037 Both reqs high, single bytes 8'h41 (cd=1, last=1) and 8'h01 (cd=0, last=1): bytes in order req0 then req1, ena_write 1 cycle after the req, each ack 1 cycle after done.
REQ-038 Burst of 3 bytes (req0) with req1 high throughout: ena_write three times for req0 with grant0 held, grant1 asserted only after ack0 on the last byte.
REQ-039 done_write withheld, TIMEOUT_CYC=16: timeout_err=1 after 16 WAIT cycles, no ack, grant dropped, next IDLE grant goes to the other requester.
REQ-040 Owner drops req in HOLD after byte 1 of 3: release to IDLE, no further ena_write for that owner, pointer flipped.
REQ-041 rst_n asserted during WAIT: all outputs at reset values in the same cycle; a spurious done_write after reset produces no ack.
